// File: rtl/beat_event_framer.sv
// beat_event_framer: frames SYNC/HDR/LEN/payload/CHK byte packets from an
// unthrottled byte stream, timestamps each good packet with a free-running
// tick counter and flags discarded packets with a one-cycle error pulse.
//
// Byte handshake: rx_valid high for one cycle carries exactly one byte on
// rx_data; there is no ready/backpressure, so every valid byte is consumed
// on the cycle it arrives.
module beat_event_framer #(
   parameter int          CLK_PER_TICK   = 50000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          MAX_LEN        = 15,
   parameter int          TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  header,
   output logic [31:0] counter,
   output logic        pkt_err
);

   localparam int PW = $clog2(CLK_PER_TICK);
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_TICK - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] GET_HDR = 3'd1;
   localparam logic [2:0] GET_LEN = 3'd2;
   localparam logic [2:0] GET_PAY = 3'd3;
   localparam logic [2:0] GET_CHK = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [31:0]   tick_q, tick_d;
   logic [31:0]   ts_q, ts_d;
   logic [7:0]    hdr_q, hdr_d;
   logic [7:0]    chk_q, chk_d;
   logic [7:0]    rem_q, rem_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    header_q, header_d;
   logic [31:0]   counter_q, counter_d;
   logic          pkt_err_q, pkt_err_d;
   logic          good, err;

   // Prescaler wraps every CLK_PER_TICK cycles and advances the tick count.
   always_comb begin
      pre_d  = pre_q + 1'b1;
      tick_d = tick_q;
      if (pre_q == PRE_LAST) begin
         pre_d  = '0;
         tick_d = tick_q + 32'd1;
      end
   end

   // Packet FSM, running checksum, payload countdown and inter-byte gap timer.
   always_comb begin
      state_d = state_q;
      ts_d    = ts_q;
      hdr_d   = hdr_q;
      chk_d   = chk_q;
      rem_d   = rem_q;
      good    = 1'b0;
      err     = 1'b0;
      if (rx_valid || state_q == IDLE) gap_d = '0;
      else                             gap_d = gap_q + 1'b1;

      if (rx_valid) begin
         case (state_q)
            IDLE: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d = GET_HDR;
                  ts_d    = tick_q;
               end
            end
            GET_HDR: begin
               if (rx_data == 8'd0) begin
                  err = 1'b1;
               end else begin
                  hdr_d   = rx_data;
                  chk_d   = rx_data;
                  state_d = GET_LEN;
               end
            end
            GET_LEN: begin
               chk_d = chk_q ^ rx_data;
               if (rx_data > MAX_LEN_B) begin
                  err = 1'b1;
               end else if (rx_data == 8'd0) begin
                  state_d = GET_CHK;
               end else begin
                  rem_d   = rx_data;
                  state_d = GET_PAY;
               end
            end
            GET_PAY: begin
               chk_d = chk_q ^ rx_data;
               rem_d = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = GET_CHK;
            end
            GET_CHK: begin
               if (rx_data == chk_q) good = 1'b1;
               else                  err  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && gap_q == GAP_LAST) begin
         // A byte on the deadline cycle takes the branch above instead.
         err = 1'b1;
      end

      if (err) begin
         state_d = IDLE;
         gap_d   = '0;
      end
   end

   // Registered outputs: header pulses only on a good packet, counter holds.
   always_comb begin
      header_d  = good ? hdr_q : 8'd0;
      counter_d = good ? ts_q : counter_q;
      pkt_err_d = err;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         tick_q    <= '0;
         ts_q      <= '0;
         hdr_q     <= '0;
         chk_q     <= '0;
         rem_q     <= '0;
         gap_q     <= '0;
         header_q  <= '0;
         counter_q <= '0;
         pkt_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         tick_q    <= tick_d;
         ts_q      <= ts_d;
         hdr_q     <= hdr_d;
         chk_q     <= chk_d;
         rem_q     <= rem_d;
         gap_q     <= gap_d;
         header_q  <= header_d;
         counter_q <= counter_d;
         pkt_err_q <= pkt_err_d;
      end
   end

   assign header  = header_q;
   assign counter = counter_q;
   assign pkt_err = pkt_err_q;

endmodule

// File: tb/tb_beat_event_framer.sv
// Bench for beat_event_framer: packets are built at packet level, and each
// packet's outcome (good header pulse with its SYNC-cycle tick, or an error
// pulse) is queued with the cycle it must appear on.
module tb_beat_event_framer;

   localparam int         CPT  = 4;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         MAXL = 15;
   localparam int         TMO  = 8;

   localparam int K_GOOD    = 0;
   localparam int K_BADCHK  = 1;
   localparam int K_BADLEN  = 2;
   localparam int K_ZEROHDR = 3;
   localparam int K_TIMEOUT = 4;
   localparam int K_LATE    = 5;

   typedef struct {
      int          cyc;
      bit          err;
      logic [7:0]  hdr;
      logic [31:0] ts;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  header;
   logic [31:0] counter;
   logic        pkt_err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          max_gap = 3;
   logic [31:0] exp_counter = 0;
   ev_t         exp_q[$];
   ev_t         mon_ev;
   logic [7:0]  pay_buf [16];

   beat_event_framer #(
      .CLK_PER_TICK(CPT), .SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .header(header), .counter(counter), .pkt_err(pkt_err)
   );

   // clock / cycle index (value at a negedge = index of the next posedge)
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void push(input int c, input bit e, input logic [7:0] h, input logic [31:0] ts);
      ev_t ev;
      ev.cyc = c; ev.err = e; ev.hdr = h; ev.ts = ts;
      exp_q.push_back(ev);
   endfunction

   // scoreboard: compare outputs every cycle against the expected event queue
   always @(negedge clk) begin
      if (!rst) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.err) begin
               check("err_pulse", {31'd0, pkt_err}, 32'd1);
               check("err_no_header", {24'd0, header}, 32'd0);
            end else begin
               check("good_header", {24'd0, header}, {24'd0, mon_ev.hdr});
               check("good_no_err", {31'd0, pkt_err}, 32'd0);
               exp_counter = mon_ev.ts;
            end
         end else begin
            check("quiet_header", {24'd0, header}, 32'd0);
            check("quiet_err", {31'd0, pkt_err}, 32'd0);
         end
         check("counter", counter, exp_counter);
      end
   end

   // driver tasks: every call owns exactly one or more whole cycles
   task automatic send_byte(input logic [7:0] d, output int idx);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = d;
      idx      = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
      end
   endtask

   task automatic pgap();
      idle($urandom_range(0, max_gap));
   endtask

   task automatic garbage();
      int idx;
      logic [7:0] b;
      repeat ($urandom_range(0, 2)) begin
         if ($urandom_range(0, 1) == 1) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send_byte(b, idx);
         end else begin
            idle(1);
         end
      end
   endtask

   task automatic send_packet(input int kind, input logic [7:0] hdr, input logic [7:0] len,
                              input logic [7:0] mask);
      int s, idx;
      logic [31:0] ts;
      logic [7:0] chk;
      send_byte(SYNC, s);
      ts = 32'(s / CPT);
      pgap();
      if (kind == K_ZEROHDR) begin
         send_byte(8'd0, idx);
         push(idx, 1'b1, 8'd0, 0);
         return;
      end
      send_byte(hdr, idx);
      if (kind == K_TIMEOUT) begin
         push(idx + TMO, 1'b1, 8'd0, 0);
         idle(TMO);
         return;
      end
      if (kind == K_LATE) idle(TMO - 1);
      else                pgap();
      send_byte(len, idx);
      if (kind == K_BADLEN) begin
         push(idx, 1'b1, 8'd0, 0);
         return;
      end
      chk = hdr ^ len;
      for (int i = 0; i < int'(len); i++) begin
         pgap();
         send_byte(pay_buf[i], idx);
         chk = chk ^ pay_buf[i];
      end
      pgap();
      if (kind == K_BADCHK) begin
         send_byte(chk ^ mask, idx);
         push(idx, 1'b1, 8'd0, 0);
      end else begin
         send_byte(chk, idx);
         push(idx, 1'b0, hdr, ts);
      end
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      exp_q.delete();
      repeat (n) @(negedge clk);
      check("rst_header", {24'd0, header}, 32'd0);
      check("rst_counter", counter, 32'd0);
      check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
      exp_counter = 0;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, kind, r;
      logic [7:0] h, l;
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_header", {24'd0, header}, 32'd0);
      check("rst_counter", counter, 32'd0);
      check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
      rst = 1'b0;
      idle(40);

      // directed: good packet at tick 10, bad checksum, length/header errors
      max_gap = 0;
      pay_buf[0] = 8'h11; pay_buf[1] = 8'h22;
      send_packet(K_GOOD, 8'h04, 8'd2, 8'h00);
      send_packet(K_BADCHK, 8'h06, 8'd0, 8'h01);
      send_packet(K_BADLEN, 8'h04, 8'h10, 8'h00);
      send_packet(K_ZEROHDR, 8'h04, 8'd0, 8'h00);
      // timeout, then a byte exactly on the deadline cycle
      send_packet(K_TIMEOUT, 8'h04, 8'd0, 8'h00);
      send_packet(K_LATE, 8'h04, 8'd0, 8'h00);
      // back-to-back good packets, maximum length included
      for (int i = 0; i < 16; i++) pay_buf[i] = 8'($urandom);
      send_packet(K_GOOD, 8'h33, 8'd15, 8'h00);
      send_packet(K_GOOD, 8'h44, 8'd1, 8'h00);
      send_packet(K_GOOD, 8'hFF, 8'd0, 8'h00);
      idle(3);

      // reset in the middle of a packet
      send_byte(SYNC, idx);
      send_byte(8'h04, idx);
      send_byte(8'h02, idx);
      apply_reset(2);
      pay_buf[0] = 8'h11; pay_buf[1] = 8'h22;
      send_packet(K_GOOD, 8'h04, 8'd2, 8'h00);

      // randomized packets
      max_gap = 3;
      repeat (80) begin
         r = $urandom_range(0, 9);
         kind = (r < 5) ? K_GOOD : r - 4;
         h = 8'($urandom_range(1, 255));
         l = (kind == K_BADLEN) ? 8'($urandom_range(MAXL + 1, 255)) : 8'($urandom_range(0, MAXL));
         for (int i = 0; i < 16; i++) pay_buf[i] = 8'($urandom);
         send_packet(kind, h, l, 8'($urandom_range(1, 255)));
         if ($urandom_range(0, 3) != 0) garbage();
      end
      idle(TMO + 4);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/beat_event_framer.md
BEAT_EVENT_FRAMER -- requirements
Module: beat_event_framer

Interface
REQ-001 The block SHALL have parameter CLK_PER_TICK, default 50000, meaning clk cycles per timestamp tick (1 ms at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the packet start marker.
REQ-003 The block SHALL have parameter MAX_LEN, default 15, meaning the maximum payload length in bytes.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum idle gap in clk cycles between bytes inside a packet.
REQ-005 The block SHALL have port clk, input, width 1: single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port rx_data, input, width 8: received byte.
REQ-008 The block SHALL have port rx_valid, input, width 1: rx_data is valid this cycle; each high cycle carries one byte; there is no backpressure.
REQ-009 The block SHALL have port header, output, width 8: the accepted packet header byte, non-zero for exactly one cycle per good packet and 8'd0 otherwise.
REQ-010 The block SHALL have port counter, output, width 32: the tick timestamp of the last good packet, held between packets.
REQ-011 The block SHALL have port pkt_err, output, width 1: one-cycle pulse when a packet is discarded.

Function
REQ-012 Prescaler SHALL count 0..CLK_PER_TICK-1 and wrap; on each wrap, the 32-bit tick register SHALL increment, wrapping from 32'hFFFFFFFF to 0.
REQ-013 Packet format SHALL be: SYNC_BYTE, HDR, LEN, LEN payload bytes, CHK, where CHK = XOR of HDR, LEN and all payload bytes.
REQ-014 FSM states SHALL be IDLE, GET_HDR, GET_LEN, GET_PAY, GET_CHK.
REQ-015 In IDLE, a byte equal to SYNC_BYTE SHALL cause a move to GET_HDR and capture the tick register value of that same cycle as the pending timestamp; any other byte SHALL be ignored silently.
REQ-016 In GET_HDR, HDR == 8'd0 SHALL cause an error; otherwise the block SHALL store HDR, set the running checksum to HDR, and move to GET_LEN.
REQ-017 In GET_LEN, LEN > MAX_LEN SHALL cause an error; LEN == 0 SHALL cause a move to GET_CHK; otherwise the block SHALL move to GET_PAY; in all cases LEN SHALL be XORed into the checksum.
REQ-018 In GET_PAY, each byte SHALL be XORed into the checksum; after the LEN-th byte the block SHALL move to GET_CHK.
REQ-019 Bytes equal to SYNC_BYTE SHALL be treated as plain data outside IDLE; there is no mid-packet resync.
REQ-020 In GET_CHK, a byte matching the checksum SHALL be a good packet; the next cycle, header SHALL equal the stored HDR for one cycle, counter SHALL be updated to the pending timestamp on that same cycle, and the FSM SHALL return to IDLE.
REQ-021 In GET_CHK, a mismatching byte SHALL cause an error.
REQ-022 On any error, pkt_err SHALL pulse for one cycle on the next cycle, the FSM SHALL return to IDLE, and header and counter SHALL be unchanged.
REQ-023 Latency from the accepted CHK byte to the header pulse SHALL be exactly 1 cycle.
REQ-024 A byte arriving on the cycle of the header or pkt_err pulse SHALL be processed by IDLE normally.
REQ-025 The gap counter SHALL clear on every rx_valid and increment each cycle while the FSM is outside IDLE without rx_valid.
REQ-026 Reaching TIMEOUT_CYCLES on the gap counter SHALL cause an error.
REQ-027 When rx_valid coincides with the cycle the gap counter would reach TIMEOUT_CYCLES, the byte SHALL win and no timeout SHALL occur.
REQ-028 header SHALL be registered and SHALL never show a stored HDR outside the one-cycle pulse.

Reset
REQ-029 While rst is high, the following SHALL be forced to zero or their initial value: FSM=IDLE, prescaler=0, tick=0, counter=0, header=0, pkt_err=0, gap counter=0, checksum=0, pending timestamp=0.
REQ-030 Reset mid-packet SHALL discard the partial packet with no pkt_err pulse.
REQ-031 The first byte SHALL be sampled on the first cycle with rst low.

Verification
REQ-032 Good packet scenario: with CLK_PER_TICK=4 and ticks at 10, send A5,04,02,11,22,CHK=04^02^11^22=35 -> header=04 for 1 cycle, counter=10, pkt_err=0.
REQ-033 Bad checksum scenario: send A5,06,00,07 (expected 06) -> pkt_err pulses once, header stays 00, counter keeps its previous value.
REQ-034 Length and header errors scenario: send A5,04,10 (LEN=16), then A5,00 -> two pkt_err pulses, FSM returns to IDLE, no header pulse.
REQ-035 Timeout scenario: with TIMEOUT_CYCLES=8, send A5,04 then idle 8 cycles -> pkt_err pulses; with a byte on the 8th idle cycle instead -> no error.
REQ-036 Wrap and back-to-back scenario: preload tick=FFFFFFFF, advance one tick -> tick=0; two good packets with no gap -> two header pulses, each counter equal to its own SYNC-cycle tick.
REQ-037 Reset scenario: assert rst after A5,04,02 -> no pkt_err, all outputs 0; then a good packet decodes normally.
